ram_bist_ctrl: RTL and testbench
================================

// Module: ram_bist_ctrl
// PURPOSE
//  Sequencer/checker that drives the single-port block RAM (32x8, 1-cycle read) from the RAM's port side.
//  On a start pulse it writes a seeded address pattern to every location, then reads every location back.
//  It compares the read data against the expected value and reports done/pass, an error count and the first failing address.
//  Used as the stimulus/self-test stage feeding the RAM instance in the board top.
// PARAMETERS
//  ADDR_W  5      RAM address width
//  DATA_W  8      RAM data width
//  DEPTH   32     locations exercised, 2..2**ADDR_W
//  RD_LAT  1      RAM read latency in cycles (1 or 2)
//  SEED    8'h00  pattern offset: data = (addr + SEED) mod 2**DATA_W
// PORTS
//  sys_clk         in   1       sole clock, rising edge
//  sys_rst         in   1       synchronous reset, active-high
//  start           in   1       1-cycle pulse; starts a run when not busy
//  inject_err      in   1       sampled with start; if 1, location 3 is written with ~pattern
//  ram_en          out  1       RAM enable
//  ram_we          out  1       RAM write enable
//  ram_addr        out  ADDR_W  RAM address
//  ram_wr_data     out  DATA_W  RAM write data
//  ram_rd_data     in   DATA_W  RAM read data, valid RD_LAT cycles after read address
//  busy            out  1       run in progress
//  done            out  1       run complete; held until next start or reset
//  pass            out  1       valid while done: 1 = err_cnt==0
//  err_cnt         out  ADDR_W+1  mismatch count for the run; saturates at all-ones
//  first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  All outputs are registered. While sys_rst=1, each edge clears every output to 0 and forces IDLE.
//  Reset mid-run aborts: ram_en/ram_we are 0 from the next edge, and counters and flags are cleared.
//  FSM IDLE -> WRITE -> READ -> DRAIN -> DONE; from DONE, start -> WRITE (new run).
//  IDLE/DONE: ram_en=ram_we=0, ram_addr=0, busy=0. A start sampled here clears done, pass, err_cnt, first_err_addr and the pipeline.
//    It latches inject_err, sets busy=1 and enters WRITE with addr=0.
//  start while busy is ignored (no restart, no effect on counters).
//  WRITE: ram_en=1, ram_we=1, ram_wr_data=addr+SEED (low DATA_W bits; ~ of it at addr 3 if injected).
//    addr increments by 1 each cycle; after addr=DEPTH-1, go to READ with addr=0.
//  READ: ram_en=1, ram_we=0, addr 0..DEPTH-1 one per cycle.
//    Expected data and a valid bit enter an RD_LAT-deep shift pipe alongside the address.
//    After addr DEPTH-1, go to DRAIN.
//  DRAIN: ram_en=0. Stays RD_LAT cycles for the last read to return, then goes to DONE.
//  Compare: when the pipe-out valid bit is 1 and ram_rd_data != expected, err_cnt increments (saturating).
//    On the first mismatch of the run, first_err_addr captures that address.
//    Expected is always the un-inverted pattern, so an injected run yields exactly 1 error.
//  DONE entry: busy=0, done=1, pass=(final err_cnt==0), including the compare of the last location.
//  Timing: the start edge is edge 0. Writes occur on edges 1..DEPTH and reads are issued on edges DEPTH+1..2*DEPTH.
//    done rises on edge 2*DEPTH+RD_LAT+1 (DEPTH=32, RD_LAT=1: edge 66).
//  Address wrap: if DEPTH=2**ADDR_W, the counter end test uses DEPTH-1, not overflow.
//  Pattern wraps mod 2**DATA_W when DEPTH+SEED exceeds 2**DATA_W.
//  start coincident with sys_rst: reset wins, and the block stays IDLE.
// TESTING
//  1 Clean run: RAM model with RD_LAT=1, pulse start at edge 0.
//    -> 32 writes addr0..31 data 0x00..0x1F, then 32 reads; done@66, pass=1, err_cnt=0.
//  2 Injection: start with inject_err=1.
//    -> write at addr 3 = 0xFC; done, pass=0, err_cnt=1, first_err_addr=3.
//  3 Faulty RAM: model with stuck-at-0 on data bit 4.
//    -> err_cnt=16 (addrs 16..31), first_err_addr=16, pass=0.
//  4 Busy/restart: start pulses at edges 10 and 40 ignored; start after done clears flags.
//    -> second run identical to scenario 1.
//  5 Reset mid-run: sys_rst=1 at edge 45 (READ).
//    -> next edge ram_en=0, busy=0, done=0, err_cnt=0; a later start completes normally.
//  6 Params RD_LAT=2, SEED=8'hF0.
//    -> data 0xF0..0xFF then 0x00..0x0F; done@67, pass=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
//   Self-test sequencer for a single-port block RAM, driven from the RAM's
//   port side. On a start pulse it writes (addr + SEED) to every location
//   0..DEPTH-1, then reads every location back. Each returned word is compared
//   against the un-inverted pattern. At the end it reports done/pass, a
//   saturating error count and the first failing address.
//
// Ports
//   sys_clk, sys_rst       clock (rising edge), synchronous active-high reset
//   start                  1-cycle pulse; accepted only when not busy
//   inject_err             sampled with an accepted start; corrupts location 3
//   ram_en, ram_we         RAM enable / write enable
//   ram_addr, ram_wr_data  RAM address / write data
//   ram_rd_data            RAM read data, RD_LAT cycles after the read address
//   busy                   run in progress
//   done                   run complete; held until the next start or reset
//   pass                   valid while done: 1 when err_cnt == 0
//   err_cnt                mismatch count for the run, saturating
//   first_err_addr         address of the first mismatch (0 if none)
//   fsm_state              current sequencer state, for observation only
//
// Handshake: there is no ready/valid pair. start is a single-cycle request
// that is accepted only in IDLE or DONE; in any other state it is dropped.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module ram_bist_ctrl #(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 32,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED   = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              inject_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // End-of-sweep is detected by comparing against DEPTH-1, so a full
    // 2**ADDR_W sweep never relies on the address counter overflowing.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                DC_W      = $clog2(RD_LAT + 1);
    localparam logic [DC_W-1:0]   DRAIN_END = DC_W'(RD_LAT);

    logic [2:0]        state;
    logic              inj_q;
    logic [DC_W-1:0]   drain_cnt;

    // Compare pipe: stage 1 captures the read that the RAM samples on the
    // same edge; stage RD_LAT lines up with the returned ram_rd_data.
    logic              pipe_v    [1:RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [1:RD_LAT];
    logic [DATA_W-1:0] pipe_exp  [1:RD_LAT];

    assign fsm_state = state;

    // Pattern word for an address; the sum wraps naturally at DATA_W bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic              inj);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) + SEED;
        if (inj && (int'(a) == 3)) begin
            p = ~p;
        end
        return p;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= S_IDLE;
            inj_q          <= 1'b0;
            drain_cnt      <= '0;
            ram_en         <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wr_data    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            // Expected value is always the clean pattern, so an injected
            // location shows up as exactly one mismatch.
            pipe_v[1]    <= (state == S_READ);
            pipe_addr[1] <= ram_addr;
            pipe_exp[1]  <= pattern(ram_addr, 1'b0);
            for (int i = 2; i <= RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end

            if (pipe_v[RD_LAT] && (ram_rd_data != pipe_exp[RD_LAT])) begin
                // err_cnt never returns to zero within a run, so zero marks
                // the first mismatch.
                if (err_cnt == '0) begin
                    first_err_addr <= pipe_addr[RD_LAT];
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        inj_q          <= inject_err;
                        busy           <= 1'b1;
                        state          <= S_WRITE;
                        ram_en         <= 1'b1;
                        ram_we         <= 1'b1;
                        ram_addr       <= '0;
                        ram_wr_data    <= pattern('0, inject_err);
                        for (int i = 1; i <= RD_LAT; i++) begin
                            pipe_v[i] <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (ram_addr == LAST_ADDR) begin
                        state       <= S_READ;
                        ram_we      <= 1'b0;
                        ram_addr    <= '0;
                        ram_wr_data <= '0;
                    end else begin
                        ram_addr    <= ram_addr + 1'b1;
                        ram_wr_data <= pattern(ram_addr + 1'b1, inj_q);
                    end
                end
                S_READ: begin
                    if (ram_addr == LAST_ADDR) begin
                        state     <= S_DRAIN;
                        ram_en    <= 1'b0;
                        ram_addr  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last compare lands one edge before DONE entry, so
                    // pass below already sees the final err_cnt.
                    if (drain_cnt == DRAIN_END) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl
//   Bench for ram_bist_ctrl. Two instances share clock, reset and start:
//   dut_a uses the default parameters with a 1-cycle RAM model that can
//   force data bits; dut_b uses RD_LAT=2, SEED=8'hF0 with a clean 2-cycle RAM.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic inj;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- dut_a (defaults) ----------------
    logic       en_a, we_a, busy_a, done_a, pass_a;
    logic [4:0] addr_a, ferr_a;
    logic [7:0] wd_a, rd_a;
    logic [5:0] err_a;
    logic [2:0] st_a;

    ram_bist_ctrl dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(start), .inject_err(inj),
        .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wr_data(wd_a),
        .ram_rd_data(rd_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_err_addr(ferr_a), .fsm_state(st_a)
    );

    // ---------------- dut_b (RD_LAT=2, SEED=F0) ----------------
    logic       en_b, we_b, busy_b, done_b, pass_b;
    logic [4:0] addr_b, ferr_b;
    logic [7:0] wd_b, rd_b;
    logic [5:0] err_b;
    logic [2:0] st_b;

    ram_bist_ctrl #(.RD_LAT(2), .SEED(8'hF0)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(start), .inject_err(inj),
        .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wr_data(wd_b),
        .ram_rd_data(rd_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_err_addr(ferr_b), .fsm_state(st_b)
    );

    // ---------------- RAM models ----------------
    logic [7:0] mem_a [32];
    logic [7:0] q_a;
    logic [7:0] and_m = 8'h00;  // bits forced low on read
    logic [7:0] or_m  = 8'h00;  // bits forced high on read
    assign rd_a = (q_a & ~and_m) | or_m;

    always @(posedge clk) begin
        if (en_a && we_a)  mem_a[addr_a] <= wd_a;
        if (en_a && !we_a) q_a <= mem_a[addr_a];
    end

    logic [7:0] mem_b [32];
    logic [7:0] q1_b, q2_b;
    assign rd_b = q2_b;

    always @(posedge clk) begin
        if (en_b && we_b)  mem_b[addr_b] <= wd_b;
        if (en_b && !we_b) q1_b <= mem_b[addr_b];
        q2_b <= q1_b;
    end

    // ---------------- edge counter and port monitors ----------------
    int cyc = 0;
    int start_c = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Logged at negedge: the values seen here are sampled by the RAM on the
    // next rising edge, whose number relative to the start edge is stored.
    int         wa_edge[$], wa_addr[$], ra_edge[$], ra_addr[$];
    logic [7:0] wa_data[$], wb_data[$];

    always @(negedge clk) begin
        if (en_a && we_a) begin
            wa_edge.push_back(cyc + 1 - start_c);
            wa_addr.push_back(int'(addr_a));
            wa_data.push_back(wd_a);
        end
        if (en_a && !we_a) begin
            ra_edge.push_back(cyc + 1 - start_c);
            ra_addr.push_back(int'(addr_a));
        end
        if (en_b && we_b) wb_data.push_back(wd_b);
    end

    logic [7:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [7:0] pat(input int a, input int seed);
        int v;
        v = (a + seed) % 256;
        return v[7:0];
    endfunction

    // Whole-run outcome from the rules: what each location holds after the
    // write sweep, what the (possibly faulty) RAM returns, and which reads
    // disagree with the clean pattern.
    task automatic model(input bit m_inj, input logic [7:0] am, input logic [7:0] om,
                         input int seed, output int errs, output int first);
        logic [7:0] w, r;
        errs  = 0;
        first = 0;
        for (int a = 0; a < 32; a++) begin
            w = pat(a, seed);
            if (m_inj && a == 3) w = ~w;
            r = (w & ~am) | om;
            if (r != pat(a, seed)) begin
                if (errs == 0) first = a;
                if (errs < 63) errs++;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Issues one start (edge 0), optionally pulses start again at edges 10
    // and 40, and returns the edge on which each done rose (-1 on timeout).
    task automatic run(input bit inj_in, input bit pulse_busy,
                       output int de_a, output int de_b);
        wa_edge.delete(); wa_addr.delete(); wa_data.delete();
        ra_edge.delete(); ra_addr.delete(); wb_data.delete();
        @(negedge clk);
        start = 1'b1;
        inj   = inj_in;
        @(posedge clk);
        #1;
        start_c = cyc;
        @(negedge clk);
        start = 1'b0;
        inj   = 1'b0;
        de_a  = -1;
        de_b  = -1;
        for (int n = 1; n <= 150; n++) begin
            start = pulse_busy && (n == 10 || n == 40);
            @(posedge clk);
            #1;
            if (done_a && de_a < 0) de_a = n;
            if (done_b && de_b < 0) de_b = n;
            @(negedge clk);
            if (de_a > 0 && de_b > 0) break;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; inj = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({en_a, we_a, addr_a, wd_a, busy_a, done_a, pass_a, err_a, ferr_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_a: got en=%b we=%b addr=%0d wd=%h busy=%b done=%b pass=%b err=%0d ferr=%0d, expected all 0",
                     en_a, we_a, addr_a, wd_a, busy_a, done_a, pass_a, err_a, ferr_a);
        end
        n_checks++;
        if ({en_b, we_b, busy_b, done_b, pass_b, err_b, ferr_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_b: got en=%b we=%b busy=%b done=%b err=%0d, expected all 0",
                     en_b, we_b, busy_b, done_b, err_b);
        end
        // start coincident with reset must not launch a run
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || en_a !== 1'b0) begin
            n_fail++;
            $display("FAIL start_during_reset: got busy=%b en=%b, expected 0 0", busy_a, en_a);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || en_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b en=%b, expected 0 0", busy_a, en_a);
        end
    endtask

    task automatic test_clean;
        int da, db;
        run(1'b0, 1'b0, da, db);
        n_checks++;
        if (da !== 66) begin
            n_fail++;
            $display("FAIL clean_done_edge: got %0d expected 66", da);
        end
        n_checks++;
        if (wa_data.size() !== 32 || ra_addr.size() !== 32) begin
            n_fail++;
            $display("FAIL clean_access_count: got writes=%0d reads=%0d expected 32 32",
                     wa_data.size(), ra_addr.size());
        end else begin
            for (int i = 0; i < 32; i++) exp_q.push_back(pat(i, 0));
            for (int i = 0; i < 32; i++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (wa_data[i] !== e || wa_addr[i] !== i || wa_edge[i] !== i + 1) begin
                    n_fail++;
                    $display("FAIL clean_write[%0d]: got addr=%0d data=%h edge=%0d expected addr=%0d data=%h edge=%0d",
                             i, wa_addr[i], wa_data[i], wa_edge[i], i, e, i + 1);
                end
                n_checks++;
                if (ra_addr[i] !== i || ra_edge[i] !== 33 + i) begin
                    n_fail++;
                    $display("FAIL clean_read[%0d]: got addr=%0d edge=%0d expected addr=%0d edge=%0d",
                             i, ra_addr[i], ra_edge[i], i, 33 + i);
                end
            end
        end
        n_checks++;
        if (pass_a !== 1'b1 || err_a !== 6'd0 || ferr_a !== 5'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_result: got pass=%b err=%0d ferr=%0d busy=%b expected 1 0 0 0",
                     pass_a, err_a, ferr_a, busy_a);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL done_held: got done=%b pass=%b expected 1 1", done_a, pass_a);
        end
    endtask

    task automatic test_inject;
        int da, db, errs, first;
        run(1'b1, 1'b0, da, db);
        model(1'b1, 8'h00, 8'h00, 0, errs, first);
        n_checks++;
        if (wa_data.size() < 4 || wa_data[3] !== 8'hFC) begin
            n_fail++;
            $display("FAIL inject_write3: got %h expected fc",
                     (wa_data.size() < 4) ? 8'h00 : wa_data[3]);
        end
        n_checks++;
        if (da !== 66 || pass_a !== 1'b0 || err_a !== 6'(errs) || ferr_a !== 5'(first)) begin
            n_fail++;
            $display("FAIL inject_result: got done_edge=%0d pass=%b err=%0d ferr=%0d expected 66 0 %0d %0d",
                     da, pass_a, err_a, ferr_a, errs, first);
        end
    endtask

    // A new start from DONE must clear the previous run's flags at once.
    task automatic test_restart_clears;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (done_a !== 1'b0 || pass_a !== 1'b0 || err_a !== 6'd0 || ferr_a !== 5'd0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b pass=%b err=%0d ferr=%0d busy=%b expected 0 0 0 0 1",
                     done_a, pass_a, err_a, ferr_a, busy_a);
        end
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 150 && !seen; n++) begin
            @(posedge clk);
            #1;
            seen = done_a && done_b;
        end
        n_checks++;
        if (!seen || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_complete: got done=%b pass=%b expected 1 1", done_a, pass_a);
        end
    endtask

    task automatic test_faulty_ram;
        int da, db, errs, first;
        and_m = 8'h10;
        run(1'b0, 1'b0, da, db);
        model(1'b0, 8'h10, 8'h00, 0, errs, first);
        n_checks++;
        if (err_a !== 6'(errs) || ferr_a !== 5'(first) || pass_a !== 1'b0 || da !== 66) begin
            n_fail++;
            $display("FAIL stuck_bit4: got err=%0d ferr=%0d pass=%b done_edge=%0d expected %0d %0d 0 66",
                     err_a, ferr_a, pass_a, da, errs, first);
        end
        and_m = 8'h00;
    endtask

    task automatic test_busy_ignore;
        int da, db;
        run(1'b0, 1'b1, da, db);
        n_checks++;
        if (da !== 66 || wa_data.size() !== 32 || ra_addr.size() !== 32) begin
            n_fail++;
            $display("FAIL busy_ignore: got done_edge=%0d writes=%0d reads=%0d expected 66 32 32",
                     da, wa_data.size(), ra_addr.size());
        end
        n_checks++;
        if (pass_a !== 1'b1 || err_a !== 6'd0) begin
            n_fail++;
            $display("FAIL busy_result: got pass=%b err=%0d expected 1 0", pass_a, err_a);
        end
    endtask

    task automatic test_reset_mid;
        int da, db;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        n_checks++;
        if (busy_a !== 1'b1 || en_a !== 1'b1 || we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reading: got busy=%b en=%b we=%b expected 1 1 0", busy_a, en_a, we_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (en_a !== 1'b0 || we_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 6'd0
            || en_b !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got en=%b we=%b busy=%b done=%b err=%0d en_b=%b busy_b=%b expected all 0",
                     en_a, we_a, busy_a, done_a, err_a, en_b, busy_b);
        end
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 1'b0, da, db);
        n_checks++;
        if (da !== 66 || pass_a !== 1'b1 || db !== 67 || pass_b !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_run: got edge_a=%0d pass_a=%b edge_b=%0d pass_b=%b expected 66 1 67 1",
                     da, pass_a, db, pass_b);
        end
    endtask

    task automatic test_params;
        int da, db;
        run(1'b0, 1'b0, da, db);
        n_checks++;
        if (db !== 67 || pass_b !== 1'b1 || err_b !== 6'd0) begin
            n_fail++;
            $display("FAIL params_result: got done_edge=%0d pass=%b err=%0d expected 67 1 0", db, pass_b, err_b);
        end
        n_checks++;
        if (wb_data.size() !== 32 || wb_data[15] !== 8'hFF || wb_data[16] !== 8'h00) begin
            n_fail++;
            $display("FAIL params_wrap: got count=%0d expected 32 with ff at 15 and 00 at 16", wb_data.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (wb_data[i] !== pat(i, 240)) begin
                    n_fail++;
                    $display("FAIL params_write[%0d]: got %h expected %h", i, wb_data[i], pat(i, 240));
                end
            end
        end
    endtask

    task automatic test_random;
        int da, db, errs, first, errs_b, first_b, kind;
        bit r_inj;
        logic [7:0] b;
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            r_inj = 1'($urandom_range(0, 1));
            kind  = $urandom_range(0, 2);
            b     = 8'h01 << $urandom_range(0, 7);
            and_m = (kind == 1) ? b : 8'h00;
            or_m  = (kind == 2) ? b : 8'h00;
            run(r_inj, 1'b0, da, db);
            model(r_inj, and_m, or_m, 0, errs, first);
            model(r_inj, 8'h00, 8'h00, 240, errs_b, first_b);
            n_checks++;
            if (da !== 66 || err_a !== 6'(errs) || ferr_a !== 5'(first) || pass_a !== (errs == 0)) begin
                n_fail++;
                $display("FAIL random_a[%0d]: inj=%0d and=%h or=%h got edge=%0d err=%0d ferr=%0d pass=%b expected 66 %0d %0d %0d",
                         it, r_inj, and_m, or_m, da, err_a, ferr_a, pass_a, errs, first, errs == 0);
            end
            n_checks++;
            if (db !== 67 || err_b !== 6'(errs_b) || ferr_b !== 5'(first_b) || pass_b !== (errs_b == 0)) begin
                n_fail++;
                $display("FAIL random_b[%0d]: inj=%0d got edge=%0d err=%0d ferr=%0d pass=%b expected 67 %0d %0d %0d",
                         it, r_inj, db, err_b, ferr_b, pass_b, errs_b, first_b, errs_b == 0);
            end
        end
        and_m = 8'h00;
        or_m  = 8'h00;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean();
        test_inject();
        test_restart_clears();
        test_faulty_ram();
        test_busy_ignore();
        test_reset_mid();
        test_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
